// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned PC_W    = 3;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM, buffers one
// instruction and hands it to decode over valid/ready.
module fetch_controller #(
    parameter int unsigned PC_W      = 3,
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned LAST_ADDR = (2 ** PC_W) - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               rom_en,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump_valid,
    input  logic [PC_W-1:0]    jump_target,
    input  logic               halt_req,
    output logic               busy,
    output logic               halted
);

    import fetch_pkg::*;

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(LAST_ADDR);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    fetch_state_t        state;
    fetch_state_t        state_n;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     pc_n;
    logic [INSTR_W-1:0]  instr_n;
    logic                instr_valid_n;
    logic                handshake;
    logic                can_capture;

    assign handshake   = instr_valid && instr_ready;
    assign can_capture = !instr_valid || instr_ready;

    // ROM address is the PC register itself
    assign rom_addr = pc;

    // State, PC, instruction buffer and decoded status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            rom_en      <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_valid <= instr_valid_n;
            rom_en      <= (state_n == FETCH);
            busy        <= (state_n != IDLE);
            halted      <= (state_n == HALT) && !instr_valid_n;
        end
    end

    // Next-state: jump beats halt beats capture while fetching
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_n       = instr;
        instr_valid_n = instr_valid;

        unique case (state)
            IDLE: begin
                if (handshake) begin
                    instr_valid_n = 1'b0;
                end
                if (start) begin
                    pc_n    = '0;
                    state_n = FETCH;
                end
            end

            FETCH: begin
                if (jump_valid) begin
                    // pending instruction is on the wrong path; drop it
                    pc_n          = jump_target;
                    instr_valid_n = 1'b0;
                end else if (halt_req) begin
                    state_n = HALT;
                    if (handshake) begin
                        instr_valid_n = 1'b0;
                    end
                end else if (can_capture) begin
                    instr_n       = rom_data;
                    instr_valid_n = 1'b1;
                    pc_n          = pc + PC_ONE;
                    if (pc == LAST_PC) begin
                        state_n = HALT;
                    end
                end
            end

            HALT: begin
                if (jump_valid) begin
                    pc_n          = jump_target;
                    instr_valid_n = 1'b0;
                    state_n       = FETCH;
                end else begin
                    if (handshake) begin
                        instr_valid_n = 1'b0;
                    end
                    if (start) begin
                        state_n = FETCH;
                    end
                end
            end

            default: begin
                state_n       = IDLE;
                instr_valid_n = 1'b0;
            end
        endcase
    end

endmodule
